dcache_responder: RTL

Direct-mapped, write-through, no-write-allocate data cache that answers the pipeline's EX/MEM-stage data accesses. It sits between the pipeline's data port (address, write data, read/write strobes, read data) and a slower main-memory port with a req/ack handshake. It raises `stall` while a miss or write-through is outstanding; the hazard logic uses `stall` to freeze PC and all pipeline registers.

---
 rtl/dcache_responder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Serves pipeline loads/stores and talks to main memory over a req/ack port.
module dcache_responder #(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        mm_req,
  output logic        mm_we,
  output logic [31:0] mm_adr,
  output logic [31:0] mm_wdata,
  input  logic [31:0] mm_rdata,
  input  logic        mm_ack,
  output logic [15:0] miss_count
);

  localparam int LINES = 1 << IDX_BITS;
  localparam int TAG_W = 28 - IDX_BITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic [29:0]       lat_adr_q, lat_adr_d;
  logic [31:0]       lat_wdata_q, lat_wdata_d;
  logic [15:0]       miss_count_q, miss_count_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [31:0]       data_q [LINES][4];

  logic              data_we_s;
  logic [1:0]        data_off_s;
  logic [31:0]       data_wdata_s;
  logic              tag_we_s;

  logic [IDX_BITS-1:0] req_idx_s, lat_idx_s;
  logic [TAG_W-1:0]    req_tag_s, lat_tag_s;
  logic [1:0]          req_off_s, lat_off_s;
  logic                req_hit_s, lat_hit_s;
  logic                adr_unused_s;

  // lat_adr_q holds the word address (byte address bits 31:2) of the pending transfer
  assign req_idx_s    = adr[3+IDX_BITS:4];
  assign req_tag_s    = adr[31:4+IDX_BITS];
  assign req_off_s    = adr[3:2];
  assign lat_idx_s    = lat_adr_q[1+IDX_BITS:2];
  assign lat_tag_s    = lat_adr_q[29:2+IDX_BITS];
  assign lat_off_s    = lat_adr_q[1:0];
  assign adr_unused_s = ^adr[1:0];

  assign req_hit_s  = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);
  assign lat_hit_s  = valid_q[lat_idx_s] && (tag_q[lat_idx_s] == lat_tag_s);
  assign rdata      = data_q[req_idx_s][req_off_s];
  assign miss_count = miss_count_q;

  // Next-state, array write controls and memory-port decode
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    lat_adr_d    = lat_adr_q;
    lat_wdata_d  = lat_wdata_q;
    miss_count_d = miss_count_q;
    valid_d      = valid_q;
    data_we_s    = 1'b0;
    data_off_s   = wcnt_q;
    data_wdata_s = mm_rdata;
    tag_we_s     = 1'b0;
    stall        = 1'b0;
    mm_req       = 1'b0;
    mm_we        = 1'b0;
    mm_adr       = 32'h0000_0000;
    mm_wdata     = 32'h0000_0000;

    case (state_q)
      S_IDLE: begin
        if (mem_write) begin
          stall       = 1'b1;
          lat_adr_d   = adr[31:2];
          lat_wdata_d = wdata;
          state_d     = S_WRITE;
        end else if (mem_read && !req_hit_s) begin
          // Drop the victim line now so a partial fill is never seen as valid
          stall                = 1'b1;
          lat_adr_d            = adr[31:2];
          wcnt_d               = 2'd0;
          miss_count_d         = miss_count_q + 16'd1;
          valid_d[req_idx_s]   = 1'b0;
          state_d              = S_FILL;
        end else begin
          stall = 1'b0;
        end
      end

      S_FILL: begin
        stall  = 1'b1;
        mm_req = 1'b1;
        mm_adr = {lat_adr_q[29:2], wcnt_q, 2'b00};
        if (mm_ack) begin
          data_we_s = 1'b1;
          wcnt_d    = wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) begin
            valid_d[lat_idx_s] = 1'b1;
            tag_we_s           = 1'b1;
            state_d            = S_IDLE;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          wcnt_d = wcnt_q;
        end
      end

      S_WRITE: begin
        stall    = ~mm_ack;
        mm_req   = 1'b1;
        mm_we    = 1'b1;
        mm_adr   = {lat_adr_q, 2'b00};
        mm_wdata = lat_wdata_q;
        if (mm_ack) begin
          data_we_s    = lat_hit_s;
          data_off_s   = lat_off_s;
          data_wdata_s = lat_wdata_q;
          state_d      = S_IDLE;
        end else begin
          state_d = S_WRITE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wcnt_q       <= 2'd0;
      lat_adr_q    <= 30'd0;
      lat_wdata_q  <= 32'h0000_0000;
      miss_count_q <= 16'd0;
      valid_q      <= {LINES{1'b0}};
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      lat_adr_q    <= lat_adr_d;
      lat_wdata_q  <= lat_wdata_d;
      miss_count_q <= miss_count_d;
      valid_q      <= valid_d;
    end
  end

  // Tag and data arrays: not reset, writes suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (!rst && data_we_s) begin
      data_q[lat_idx_s][data_off_s] <= data_wdata_s;
    end
    if (!rst && tag_we_s) begin
      tag_q[lat_idx_s] <= lat_tag_s;
    end
  end

endmodule
